// File: rtl/alu_sequencer.sv
// alu_sequencer: single-request sequencer for a shared ADD/MUL/DIV/NAND datapath.
// Accepts one request at a time, drives registered operands to the external
// adder/divider/multiplier, captures the result and offers it on a
// valid/ready response channel.
// Optional feature: define ALU_SEQ_TIMEOUT_EN to add a multiplier watchdog that
// ends a stuck multiply after MUL_TIMEOUT cycles with rsp_err = 1.
module alu_sequencer #(
  parameter int MUL_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  input  logic [31:0] add_sum,
  input  logic [31:0] div_q,
  input  logic [31:0] mul_lo,
  input  logic        mul_finished,
  output logic        mul_reset,
  output logic [15:0] op_count
);

  typedef enum logic [2:0] {
    IDLE,
    EXEC,
    MUL_LOAD,
    MUL_RUN,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_MUL  = 2'b01,
    OP_DIV  = 2'b10,
    OP_NAND = 2'b11
  } opcode_t;

  // The watchdog counter is 16 bits wide, so the limit must fit in it.
  if (MUL_TIMEOUT < 2 || MUL_TIMEOUT > 65535) begin : g_bad_timeout
    $error("alu_sequencer: MUL_TIMEOUT must be in 2..65535");
  end

  state_t      state;
  state_t      state_next;
  opcode_t     opcode;
  logic        accept;
  logic        capture;
  logic [31:0] cap_data;
  logic        cap_err;
  logic        rsp_hs;

`ifdef ALU_SEQ_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(MUL_TIMEOUT - 1);
  logic [15:0] wd_cnt;
  logic        wd_clear;
  logic        wd_inc;
`endif

  // State register; reset drops any operation in flight back to IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state decode, handshake outputs and result selection.
  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    mul_reset  = 1'b1;
    accept     = 1'b0;
    capture    = 1'b0;
    cap_data   = '0;
    cap_err    = 1'b0;
    rsp_hs     = 1'b0;
`ifdef ALU_SEQ_TIMEOUT_EN
    wd_clear   = 1'b0;
    wd_inc     = 1'b0;
`endif
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept     = 1'b1;
          state_next = (opcode_t'(req_op) == OP_MUL) ? MUL_LOAD : EXEC;
        end
      end
      EXEC: begin
        capture    = 1'b1;
        state_next = DONE;
        case (opcode)
          OP_ADD:  cap_data = add_sum;
          OP_DIV: begin
            if (op_b == 32'd0) begin
              cap_data = '0;
              cap_err  = 1'b1;
            end else begin
              cap_data = div_q;
            end
          end
          OP_NAND: cap_data = ~(op_a & op_b);
          default: cap_data = '0;
        endcase
      end
      MUL_LOAD: begin
        state_next = MUL_RUN;
`ifdef ALU_SEQ_TIMEOUT_EN
        wd_clear   = 1'b1;
`endif
      end
      MUL_RUN: begin
        mul_reset = 1'b0;
        if (mul_finished) begin
          capture    = 1'b1;
          cap_data   = mul_lo;
          state_next = DONE;
        end
`ifdef ALU_SEQ_TIMEOUT_EN
        else if (wd_cnt == TMO_LAST) begin
          capture    = 1'b1;
          cap_data   = '0;
          cap_err    = 1'b1;
          state_next = DONE;
        end else begin
          wd_inc = 1'b1;
        end
`endif
      end
      DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          rsp_hs     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand/opcode latch, response capture and completed-response counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_a     <= '0;
      op_b     <= '0;
      opcode   <= OP_ADD;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
      op_count <= '0;
    end else begin
      if (accept) begin
        op_a   <= req_a;
        op_b   <= req_b;
        opcode <= opcode_t'(req_op);
      end
      if (capture) begin
        rsp_data <= cap_data;
        rsp_err  <= cap_err;
      end
      if (rsp_hs) op_count <= op_count + 16'd1;
    end
  end

`ifdef ALU_SEQ_TIMEOUT_EN
  // Watchdog: counts MUL_RUN cycles, restarted by each pass through MUL_LOAD.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        wd_cnt <= '0;
    else if (wd_clear) wd_cnt <= '0;
    else if (wd_inc)   wd_cnt <= wd_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed vector bench for alu_sequencer with a behavioural
// adder/divider/multiplier; the multiplier raises mul_finished mulDelay cycles
// after mul_reset falls.
module tb_alu_sequencer;

`ifdef ALU_SEQ_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 64;
`endif

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] add_sum;
  logic [31:0] div_q;
  logic [31:0] mul_lo;
  logic        mul_finished;
  logic        mul_reset;
  logic [15:0] op_count;

  int checks = 0;
  int errors = 0;
  int mulDelay = 10;
  int mulCnt = 0;
  int expCount = 0;

  alu_sequencer #(.MUL_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .op_a(op_a), .op_b(op_b),
    .add_sum(add_sum), .div_q(div_q), .mul_lo(mul_lo),
    .mul_finished(mul_finished), .mul_reset(mul_reset), .op_count(op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural datapath; divide-by-zero returns junk the sequencer must mask.
  assign add_sum = op_a + op_b;
  assign mul_lo  = op_a * op_b;
  assign div_q   = (op_b == 32'd0) ? 32'hDEADBEEF : op_a / op_b;

  // Multiplier latency model: counts cycles since mul_reset fell.
  always @(posedge clk) mulCnt <= mul_reset ? 0 : mulCnt + 1;
  assign mul_finished = !mul_reset && (mulCnt == mulDelay);

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          delay;
    logic [31:0] data;
    logic        err;
    int          lat;
  } vec_t;

  vec_t vecs[11];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  // Waits for req_ready, presents one request for a single accepting edge.
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a,
                               input logic [31:0] b);
    int n = 0;
    while (!req_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL req_ready_timeout: got 0 expected 1");
    end
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Counts cycles from acceptance until rsp_valid is seen.
  task automatic waitRsp(output int lat);
    lat = 0;
    while (!rsp_valid && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    if (!rsp_valid) begin
      checks++;
      errors++;
      $display("[TB] FAIL rsp_valid_timeout: got 0 expected 1");
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    int lat;
    vecs[0] = '{2'b00, 32'd24,         32'd44,         0,  32'd68,         1'b0, 1};
    vecs[1] = '{2'b00, 32'hFFFFFFFF,   32'd2,          0,  32'd1,          1'b0, 1};
    vecs[2] = '{2'b01, 32'd56,         32'd44,         10, 32'd2464,       1'b0, 12};
    vecs[3] = '{2'b01, 32'h00010000,   32'h00010003,   3,  32'h00030000,   1'b0, 5};
    vecs[4] = '{2'b10, 32'd64000,      32'd10,         0,  32'd6400,       1'b0, 1};
    vecs[5] = '{2'b10, 32'd99,         32'd0,          0,  32'd0,          1'b1, 1};
    vecs[6] = '{2'b11, 32'hFFFF0000,   32'h0F0F0F0F,   0,  32'hF0F0FFFF,   1'b0, 1};
    vecs[7] = '{2'b11, 32'h12345678,   32'hFFFFFFFF,   0,  32'hEDCBA987,   1'b0, 1};
    vecs[8] = '{2'b01, 32'd7,          32'd6,          0,  32'd42,         1'b0, 2};
`ifdef ALU_SEQ_TIMEOUT_EN
    vecs[9]  = '{2'b01, 32'd3, 32'd5, TMO,     32'd0,  1'b1, TMO + 1};
    vecs[10] = '{2'b01, 32'd3, 32'd5, TMO - 1, 32'd15, 1'b0, TMO + 1};
`else
    vecs[9]  = '{2'b01, 32'd3, 32'd5, TMO + 20, 32'd15, 1'b0, TMO + 22};
    vecs[10] = '{2'b01, 32'd9, 32'd9, 1,        32'd81, 1'b0, 3};
`endif

    reset     = 1'b0;
    req_valid = 1'b0;
    req_op    = 2'b00;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("rst_rsp_data", rsp_data, 32'd0);
    checkOutput("rst_mul_reset", {31'd0, mul_reset}, 32'd1);
    checkOutput("rst_op_count", {16'd0, op_count}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_req_ready", {31'd0, req_ready}, 32'd1);

    for (int i = 0; i < 11; i++) begin
      mulDelay = vecs[i].delay;
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b);
      waitRsp(lat);
      $display("[TB] vector %0d op=%0d latency=%0d", i, vecs[i].op, lat);
      checkOutput($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      checkOutput($sformatf("v%0d_rsp_data", i), rsp_data, vecs[i].data);
      checkOutput($sformatf("v%0d_rsp_err", i), {31'd0, rsp_err}, {31'd0, vecs[i].err});
      checkOutput($sformatf("v%0d_op_a", i), op_a, vecs[i].a);
      checkOutput($sformatf("v%0d_op_b", i), op_b, vecs[i].b);
      @(negedge clk);
      expCount++;
      checkOutput($sformatf("v%0d_op_count", i), {16'd0, op_count}, expCount);
      checkOutput($sformatf("v%0d_rsp_valid_clr", i), {31'd0, rsp_valid}, 32'd0);
    end

    // Multiplier hold/load pulse around a MUL.
    mulDelay = 10;
    applyStimulus(2'b01, 32'd56, 32'd44);
    checkOutput("mul_load_mul_reset", {31'd0, mul_reset}, 32'd1);
    @(negedge clk);
    checkOutput("mul_run_mul_reset", {31'd0, mul_reset}, 32'd0);
    waitRsp(lat);
    checkOutput("mul_done_mul_reset", {31'd0, mul_reset}, 32'd1);
    checkOutput("mul_pulse_rsp_data", rsp_data, 32'd2464);
    @(negedge clk);
    expCount++;

    // Backpressure: response held, new requests ignored.
    rsp_ready = 1'b0;
    applyStimulus(2'b11, 32'hFFFF0000, 32'h0F0F0F0F);
    waitRsp(lat);
    for (int k = 0; k < 5; k++) begin
      req_valid = 1'b1;
      req_op    = 2'b00;
      req_a     = 32'hAAAAAAAA;
      req_b     = 32'h55555555;
      @(negedge clk);
      checkOutput($sformatf("hold%0d_rsp_valid", k), {31'd0, rsp_valid}, 32'd1);
      checkOutput($sformatf("hold%0d_rsp_data", k), rsp_data, 32'hF0F0FFFF);
      checkOutput($sformatf("hold%0d_rsp_err", k), {31'd0, rsp_err}, 32'd0);
      checkOutput($sformatf("hold%0d_req_ready", k), {31'd0, req_ready}, 32'd0);
      checkOutput($sformatf("hold%0d_op_a", k), op_a, 32'hFFFF0000);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    expCount++;
    checkOutput("hold_op_count", {16'd0, op_count}, expCount);
    checkOutput("hold_rsp_valid_clr", {31'd0, rsp_valid}, 32'd0);

    // Reset three cycles into MUL_RUN abandons the multiply.
    mulDelay = 1000;
    applyStimulus(2'b01, 32'd11, 32'd13);
    repeat (4) @(negedge clk);
    checkOutput("pre_abort_mul_reset", {31'd0, mul_reset}, 32'd0);
    reset = 1'b0;
    #1;
    checkOutput("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("abort_mul_reset", {31'd0, mul_reset}, 32'd1);
    checkOutput("abort_op_a", op_a, 32'd0);
    checkOutput("abort_op_b", op_b, 32'd0);
    checkOutput("abort_rsp_data", rsp_data, 32'd0);
    checkOutput("abort_op_count", {16'd0, op_count}, 32'd0);
    expCount = 0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("abort_req_ready", {31'd0, req_ready}, 32'd1);
    repeat (3) @(negedge clk);
    checkOutput("abort_no_rsp", {31'd0, rsp_valid}, 32'd0);

    applyStimulus(2'b00, 32'd1, 32'd2);
    waitRsp(lat);
    checkOutput("recover_rsp_data", rsp_data, 32'd3);
    @(negedge clk);
    expCount++;
    checkOutput("recover_op_count", {16'd0, op_count}, expCount);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter MUL_TIMEOUT, default 64, multiplier watchdog limit in cycles (valid 2..65535).
REQ-002 SHALL have port clk  input  1  single rising-edge clock.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-004 SHALL have ports req_valid in 1, req_ready out 1, req_op in 2 (00 ADD, 01 MUL, 10 DIV, 11 NAND), req_a in 32, req_b in 32: the request channel.
REQ-005 SHALL have ports rsp_valid out 1, rsp_ready in 1, rsp_data out 32, rsp_err out 1: the response channel.
REQ-006 SHALL have ports op_a out 32 and op_b out 32: registered operands driving the shared adder, divider and multiplier.
REQ-007 SHALL have datapath return ports add_sum in 32, div_q in 32, mul_lo in 32 (low product word) and mul_finished in 1.
REQ-008 SHALL have port mul_reset out 1: active-high hold/load for the multiplier.
REQ-009 SHALL have port op_count out 16: count of completed responses.

Function
REQ-010 SHALL use states IDLE, EXEC, MUL_LOAD, MUL_RUN and DONE.
REQ-011 req_ready SHALL be 1 only in IDLE; a request is accepted on the edge where req_valid and req_ready are both 1.
REQ-012 On acceptance, op_a/op_b SHALL load req_a/req_b and the opcode SHALL be latched; op_a/op_b stay stable until the next acceptance.
REQ-013 Acceptance of ADD, DIV or NAND SHALL go to EXEC; at the next edge the result is captured and the state goes to DONE, so rsp_valid rises one cycle after acceptance.
REQ-014 Captured results: ADD = add_sum (mod 2^32, carry dropped); DIV = div_q; NAND = ~(op_a & op_b), computed internally.
REQ-015 DIV with op_b == 0 SHALL give rsp_data = 0 and rsp_err = 1, with the same latency as a normal DIV.
REQ-016 Acceptance of MUL SHALL go to MUL_LOAD for exactly one cycle, then to MUL_RUN.
REQ-017 mul_reset SHALL be 0 only in MUL_RUN and 1 in every other state.
REQ-018 mul_finished SHALL be sampled only in MUL_RUN; when it is 1, mul_lo is captured and the state goes to DONE.
REQ-019 In DONE, rsp_valid SHALL be 1 and rsp_data/rsp_err held stable until rsp_valid and rsp_ready are both 1 at an edge; the state then goes to IDLE.
REQ-020 rsp_err SHALL be 0 for every successful operation.
REQ-021 op_count SHALL increment on each response handshake and wrap from 0xFFFF to 0.
REQ-022 req_valid SHALL be ignored outside IDLE; there is no request queueing.

Reset
REQ-023 Asserting reset SHALL immediately force: state IDLE, rsp_valid 0, rsp_data 0, rsp_err 0, op_a 0, op_b 0, op_count 0, mul_reset 1, watchdog counter 0.
REQ-024 Reset asserted mid-operation, including in MUL_RUN, SHALL abandon the operation with no response.
REQ-025 req_ready SHALL be 1 in the first cycle after reset is released.

Configuration
REQ-026 Macro ALU_SEQ_TIMEOUT_EN defined: a counter SHALL clear on entry to MUL_RUN and increment each cycle in MUL_RUN.
REQ-027 With ALU_SEQ_TIMEOUT_EN, if MUL_TIMEOUT cycles elapse without mul_finished, the block SHALL go to DONE with rsp_data = 0 and rsp_err = 1.
REQ-028 With ALU_SEQ_TIMEOUT_EN, mul_finished on the same edge as the timeout SHALL win (success).
REQ-029 Macro undefined: the block SHALL wait in MUL_RUN indefinitely and SHALL contain no watchdog logic.

Verification
REQ-030 ADD a=24, b=44, rsp_ready=1 -> rsp_valid one cycle after acceptance, rsp_data=68, rsp_err=0, op_count=1.
REQ-031 MUL a=56, b=44, model raises mul_finished 10 cycles after mul_reset falls -> mul_reset pulses high then low, rsp_data=2464.
REQ-032 DIV 64000/10 -> rsp_data=6400; then DIV 99/0 -> rsp_data=0, rsp_err=1.
REQ-033 NAND 0xFFFF0000, 0x0F0F0F0F with rsp_ready held 0 for 5 cycles -> rsp_data=0xF0F0FFFF held stable, req_ready 0 throughout.
REQ-034 reset pulled low 3 cycles into MUL_RUN -> no response, mul_reset=1, req_ready=1 after release.
REQ-035 With ALU_SEQ_TIMEOUT_EN, MUL_TIMEOUT=8, mul_finished never asserted -> rsp_err=1 after 8 MUL_RUN cycles.
